// File: rtl/multi_channel_watchdog.sv
// N-channel heartbeat watchdog on a shared prescaled tick: per-channel warn/trip flags,
// masked broadcast kill and a saturating trip-event counter.
module multi_channel_watchdog #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CLK_FREQ = 125_000_000,
  parameter int unsigned TICK_HZ  = 1000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned WARN_PCT = 80
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       heartbeat,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       clear,
  input  logic [NUM_CH-1:0]       latch_mode,
  input  logic [NUM_CH*CNT_W-1:0] timeout,
  input  logic [NUM_CH-1:0]       kill_mask,
  output logic [NUM_CH-1:0]       triggered,
  output logic [NUM_CH-1:0]       warning,
  output logic [NUM_CH*CNT_W-1:0] time_remaining,
  output logic                    kill,
  output logic [15:0]             trip_count,
  output logic                    tick
);

  localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam int unsigned MW  = CNT_W + 7;
  localparam int unsigned TW  = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {IDLE, ARMED, WARN, TRIPPED} state_t;

  state_t            state [NUM_CH];
  logic [CNT_W-1:0]  cnt   [NUM_CH];
  logic [PW-1:0]     presc;

  logic [CNT_W-1:0]  tmo [NUM_CH];
  logic [CNT_W:0]    nxt [NUM_CH];
  logic [NUM_CH-1:0] idle_force, live, trip_hit, warn_hit;
  logic [TW-1:0]     trips_now;
  logic [16:0]       trip_sum;

  // live = this cycle's tick actually advances the channel (no higher-priority event pending)
  always_comb begin
    trips_now = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      tmo[i]        = timeout[i*CNT_W +: CNT_W];
      nxt[i]        = {1'b0, cnt[i]} + (CNT_W+1)'(1);
      idle_force[i] = !enable[i] || (tmo[i] == '0);
      live[i]       = !idle_force[i] && !clear[i] && !heartbeat[i] && tick &&
                      (state[i] == ARMED || state[i] == WARN);
      trip_hit[i]   = live[i] && (nxt[i] >= {1'b0, tmo[i]});
      warn_hit[i]   = live[i] && !trip_hit[i] &&
                      (MW'(nxt[i]) * MW'(100) >= MW'(tmo[i]) * MW'(WARN_PCT));
      trips_now     = trips_now + TW'(trip_hit[i]);
    end
    trip_sum = {1'b0, trip_count} + 17'(trips_now);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc          <= '0;
      tick           <= 1'b0;
      trip_count     <= '0;
      kill           <= 1'b0;
      triggered      <= '0;
      warning        <= '0;
      time_remaining <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      presc      <= (presc == PMAX) ? '0 : presc + PW'(1);
      tick       <= (presc == PMAX);
      trip_count <= trip_sum[16] ? '1 : trip_sum[15:0];
      kill       <= |(triggered & kill_mask);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        triggered[i] <= (state[i] == TRIPPED);
        warning[i]   <= (state[i] == WARN) || (state[i] == TRIPPED);
        // clamp: a lowered timeout can leave the counter at or past it until the next tick
        time_remaining[i*CNT_W +: CNT_W] <=
          ((state[i] == ARMED || state[i] == WARN) && cnt[i] < tmo[i]) ? tmo[i] - cnt[i] : '0;

        if (idle_force[i]) begin
          state[i] <= IDLE;
          cnt[i]   <= '0;
        end else if (clear[i] || state[i] == IDLE ||
                     (heartbeat[i] && (state[i] != TRIPPED || !latch_mode[i]))) begin
          state[i] <= ARMED;
          cnt[i]   <= '0;
        end else if (trip_hit[i]) begin
          state[i] <= TRIPPED;
          cnt[i]   <= tmo[i];
        end else if (live[i]) begin
          state[i] <= warn_hit[i] ? WARN : ARMED;
          cnt[i]   <= nxt[i][CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_watchdog.sv
// Directed bench for multi_channel_watchdog: 10 clk per tick on the main instance,
// plus a tick-every-clock 8-channel instance used to drive trip_count into saturation.
module tb_multi_channel_watchdog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [3:0]  heartbeat, enable, clear, latch_mode, kill_mask;
  logic [63:0] timeout;
  logic [3:0]  triggered, warning;
  logic [63:0] time_remaining;
  logic        kill, tick;
  logic [15:0] trip_count;

  logic         s_rstn;
  logic [7:0]   s_heartbeat, s_enable, s_clear, s_latch_mode, s_kill_mask;
  logic [127:0] s_timeout;
  logic [7:0]   s_triggered, s_warning;
  logic [127:0] s_time_remaining;
  logic         s_kill, s_tick;
  logic [15:0]  s_trip_count;

  multi_channel_watchdog #(
    .NUM_CH(4), .CLK_FREQ(1000), .TICK_HZ(100), .CNT_W(16), .WARN_PCT(80)
  ) dut (
    .clk(clk), .rstn(rstn), .heartbeat(heartbeat), .enable(enable), .clear(clear),
    .latch_mode(latch_mode), .timeout(timeout), .kill_mask(kill_mask),
    .triggered(triggered), .warning(warning), .time_remaining(time_remaining),
    .kill(kill), .trip_count(trip_count), .tick(tick)
  );

  multi_channel_watchdog #(
    .NUM_CH(8), .CLK_FREQ(1), .TICK_HZ(1), .CNT_W(16), .WARN_PCT(80)
  ) dut_sat (
    .clk(clk), .rstn(s_rstn), .heartbeat(s_heartbeat), .enable(s_enable), .clear(s_clear),
    .latch_mode(s_latch_mode), .timeout(s_timeout), .kill_mask(s_kill_mask),
    .triggered(s_triggered), .warning(s_warning), .time_remaining(s_time_remaining),
    .kill(s_kill), .trip_count(s_trip_count), .tick(s_tick)
  );

  typedef struct {
    int unsigned to;
    int unsigned n;
    logic        trig;
    logic        warn;
    logic [15:0] tr;
  } vec_t;

  vec_t vecs [12];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tick();
    int unsigned w = 0;
    while (tick !== 1'b1 && w < 20) begin
      step(1);
      w++;
    end
    if (tick !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_wait: tick not seen within 20 cycles at %0t", $time);
    end
  endtask

  task automatic consume_tick();
    wait_tick();
    step(1);
  endtask

  task automatic pet_on_tick(input int unsigned ch);
    wait_tick();
    heartbeat[ch] = 1'b1;
    step(1);
    heartbeat[ch] = 1'b0;
  endtask

  function automatic logic [15:0] tr(input int unsigned ch);
    return time_remaining[ch*16 +: 16];
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    heartbeat = '0; enable = '0; clear = '0; latch_mode = '0; kill_mask = '0; timeout = '0;
    step(2);
    rstn = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic early;

    vecs[0]  = '{10,  3, 1'b0, 1'b0, 16'd7};
    vecs[1]  = '{10,  7, 1'b0, 1'b0, 16'd3};
    vecs[2]  = '{10,  8, 1'b0, 1'b1, 16'd2};
    vecs[3]  = '{10, 10, 1'b1, 1'b1, 16'd0};
    vecs[4]  = '{5,   3, 1'b0, 1'b0, 16'd2};
    vecs[5]  = '{5,   4, 1'b0, 1'b1, 16'd1};
    vecs[6]  = '{1,   1, 1'b1, 1'b1, 16'd0};
    vecs[7]  = '{3,   2, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{20, 15, 1'b0, 1'b0, 16'd5};
    vecs[9]  = '{20, 16, 1'b0, 1'b1, 16'd4};
    vecs[10] = '{100, 79, 1'b0, 1'b0, 16'd21};
    vecs[11] = '{100, 80, 1'b0, 1'b1, 16'd20};

    s_rstn = 1'b0; s_heartbeat = '0; s_enable = '0; s_clear = '0;
    s_latch_mode = '0; s_kill_mask = '0; s_timeout = '0;
    rstn = 1'b0;
    heartbeat = '0; enable = '0; clear = '0; latch_mode = '0; kill_mask = '0; timeout = '0;
    step(3);

    chk("rst_triggered", triggered, 0);
    chk("rst_warning", warning, 0);
    chk("rst_time_remaining", time_remaining[31:0] | time_remaining[63:32], 0);
    chk("rst_kill", kill, 0);
    chk("rst_trip_count", trip_count, 0);
    chk("rst_tick", tick, 0);

    // first tick exactly 10 clocks after release, one clock wide, period 10
    rstn = 1'b1;
    early = 1'b0;
    for (int k = 0; k < 9; k++) begin
      step(1);
      early = early | tick;
    end
    chk("tick_early", early, 0);
    step(1);
    chk("tick_first", tick, 1);
    step(1);
    chk("tick_width", tick, 0);
    step(9);
    chk("tick_period", tick, 1);

    // table: channel 2, fresh arm, n ticks, compare flags and remaining time
    for (int v = 0; v < 12; v++) begin
      enable[2] = 1'b0;
      step(1);
      timeout[32 +: 16] = 16'(vecs[v].to);
      enable[2] = 1'b1;
      step(1);
      repeat (vecs[v].n) consume_tick();
      step(1);
      chk($sformatf("vec%0d_triggered", v), triggered[2], vecs[v].trig);
      chk($sformatf("vec%0d_warning", v), warning[2], vecs[v].warn);
      chk($sformatf("vec%0d_time_rem", v), tr(2), vecs[v].tr);
    end
    enable[2] = 1'b0;

    // test 1: trip, kill lags triggered by a clock, single trip counted
    do_reset();
    kill_mask = 4'b0001;
    timeout[15:0] = 16'd10;
    enable[0] = 1'b1;
    step(1);
    repeat (10) consume_tick();
    step(1);
    chk("t1_triggered", triggered[0], 1);
    chk("t1_kill_lag", kill, 0);
    chk("t1_trip_count", trip_count, 1);
    step(1);
    chk("t1_kill", kill, 1);

    // test 3: latched trip ignores heartbeat, clear re-arms
    latch_mode[0] = 1'b1;
    heartbeat[0] = 1'b1;
    step(1);
    heartbeat[0] = 1'b0;
    step(2);
    chk("t3_latched_hb", {triggered[0], kill}, 2'b11);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    step(1);
    chk("t3_clear_trig", triggered[0], 0);
    chk("t3_clear_tr", tr(0), 10);
    step(1);
    chk("t3_clear_kill", kill, 0);
    latch_mode[0] = 1'b0;
    repeat (10) consume_tick();
    step(1);
    chk("t3_retrip", triggered[0], 1);
    heartbeat[0] = 1'b1;
    step(1);
    heartbeat[0] = 1'b0;
    step(1);
    chk("t3_hb_recover", {triggered[0], tr(0)}, {1'b0, 16'd10});
    chk("t3_trip_count", trip_count, 2);

    // test 2: heartbeat on every 5th tick for 100 ticks
    for (int r = 0; r < 20; r++) begin
      pet_on_tick(0);
      for (int k = 1; k <= 4; k++) begin
        consume_tick();
        step(1);
        chk("t2_hb_every5", {triggered[0], warning[0], tr(0)}, {1'b0, 1'b0, 16'(10 - k)});
      end
    end

    // test 4: two channels trip on the same tick; kill masked per channel
    do_reset();
    kill_mask = 4'b0001;
    timeout[15:0] = 16'd5;
    timeout[31:16] = 16'd5;
    enable = 4'b0011;
    step(1);
    repeat (4) consume_tick();
    step(1);
    chk("t4_warn_both", {triggered[1:0], warning[1:0], trip_count}, {2'b00, 2'b11, 16'd0});
    consume_tick();
    step(1);
    chk("t4_trip_both", triggered[1:0], 2'b11);
    chk("t4_trip_count2", trip_count, 2);
    step(1);
    chk("t4_kill_ch0", kill, 1);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    step(2);
    chk("t4_only_ch1", triggered[1:0], 2'b10);
    chk("t4_kill_masked", kill, 0);
    kill_mask = 4'b0011;
    step(2);
    chk("t4_kill_ch1", kill, 1);
    rstn = 1'b0;
    step(1);
    chk("t4_reset_kill", {kill, triggered, trip_count}, 21'd0);
    rstn = 1'b1;

    // test 5: heartbeat beats the tripping tick; lowered timeout trips on next tick
    do_reset();
    kill_mask = 4'b0001;
    timeout[15:0] = 16'd10;
    enable[0] = 1'b1;
    step(1);
    repeat (9) consume_tick();
    step(1);
    chk("t5_pre_trip", {warning[0], tr(0)}, {1'b1, 16'd1});
    pet_on_tick(0);
    step(1);
    chk("t5_hb_wins", {triggered[0], warning[0], tr(0)}, {1'b0, 1'b0, 16'd10});
    chk("t5_no_count", trip_count, 0);
    timeout[15:0] = 16'd20;
    repeat (7) consume_tick();
    step(1);
    chk("t5_cnt7", tr(0), 13);
    timeout[15:0] = 16'd3;
    step(2);
    chk("t5_no_instant_trip", {triggered[0], warning[0], tr(0)}, 18'd0);
    consume_tick();
    step(1);
    chk("t5_trip_next_tick", triggered[0], 1);
    chk("t5_trip_count", trip_count, 1);
    step(1);
    chk("t5_kill", kill, 1);

    // test 6: disable while tripped, timeout=0 holds IDLE
    enable[0] = 1'b0;
    step(2);
    chk("t6_idle_outputs", {triggered[0], warning[0], tr(0)}, 18'd0);
    step(1);
    chk("t6_idle_kill", kill, 0);
    timeout[15:0] = 16'd0;
    enable[0] = 1'b1;
    repeat (3) consume_tick();
    step(1);
    chk("t6_tmo0_idle", {triggered[0], warning[0], tr(0)}, 18'd0);
    timeout[15:0] = 16'd4;
    step(2);
    chk("t6_arm_after_tmo", tr(0), 4);

    // saturation: 8 channels, timeout 1, alternating heartbeat => 4 trips per clock
    s_rstn = 1'b1;
    s_enable = '1;
    s_timeout = {8{16'd1}};
    for (int i = 0; i < 20000; i++) begin
      s_heartbeat = ~s_heartbeat;
      step(1);
    end
    chk("sat_trip_count", s_trip_count, 16'hFFFF);
    step(10);
    chk("sat_hold", s_trip_count, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
